// File: rtl/uart_autobaud_pkg.sv
// rtl/uart_autobaud_pkg.sv - shared types and constants for the UART auto-baud detector
package uart_autobaud_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        WAIT_START,
        MEASURE,
        CALC
    } abState_t;

    // Start bit plus eight data bits of the 0x55 calibration character
    localparam int NUM_SEGMENTS = 9;
    // Nine bit periods times sixteen ticks per bit, rounded to nearest
    localparam int DIV_DENOM    = 144;
    localparam int DIV_ROUND    = 72;

endpackage

// File: rtl/uart_glitch_filter.sv
// rtl/uart_glitch_filter.sv - RxD synchroniser and stability filter with edge strobes
module uart_glitch_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic rxIn,
    output logic rxFiltered,
    output logic fallStrobe,
    output logic riseStrobe
);

    localparam int HIST_W = FILTER_LEN - 1;

    logic              sync1;
    logic              sync2;
    logic [HIST_W-1:0] history;
    logic              allHigh;
    logic              allLow;

    // The current synchronised sample plus HIST_W older ones form the FILTER_LEN window
    assign allHigh = sync2 & (&history);
    assign allLow  = ~sync2 & ~(|history);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            history    <= '1;
            rxFiltered <= 1'b1;
            fallStrobe <= 1'b0;
            riseStrobe <= 1'b0;
        end else begin
            sync1      <= rxIn;
            sync2      <= sync1;
            history    <= HIST_W'({history, sync2});
            fallStrobe <= allLow & rxFiltered;
            riseStrobe <= allHigh & ~rxFiltered;
            if (allLow) begin
                rxFiltered <= 1'b0;
            end else if (allHigh) begin
                rxFiltered <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_autobaud_detector.sv
// rtl/uart_autobaud_detector.sv - measures a 0x55 calibration character and derives the x16 baud divisor
module uart_autobaud_detector
    import uart_autobaud_pkg::*;
#(
    parameter int SEG_W      = 20,
    parameter int FILTER_LEN = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        RxD,
    output logic        rxFilteredOut,
    input  logic        startIn,
    input  logic        abortIn,
    output logic        busyOut,
    output logic [15:0] divisorOut,
    output logic        divisorValidOut,
    output logic        donePulseOut,
    output logic        errorPulseOut
);

    localparam int TOT_W = SEG_W + 4;
    localparam int CNT_W = $clog2(TOT_W);
    localparam logic [SEG_W-1:0] SEG_ONE  = SEG_W'(1);
    localparam logic [TOT_W-1:0] TOT_ONE  = TOT_W'(1);
    localparam logic [8:0]       DENOM9   = 9'(DIV_DENOM);
    localparam logic [3:0]       LAST_IDX = 4'(NUM_SEGMENTS - 1);

    abState_t          state;
    abState_t          stateNext;
    logic [3:0]        segIdx;
    logic [SEG_W-1:0]  segCnt;
    logic [SEG_W-1:0]  len0;
    logic [TOT_W-1:0]  totCnt;
    logic [TOT_W-1:0]  divQuo;
    logic [7:0]        divRem;
    logic [CNT_W-1:0]  divCnt;

    logic              fallStr;
    logic              riseStr;
    logic              edgeNow;
    logic              segMax;
    logic [SEG_W:0]    hiBound;
    logic [SEG_W-1:0]  loBound;
    logic [8:0]        trial;
    logic [8:0]        trialDiff;
    logic              trialGe;
    logic [7:0]        remNext;
    logic [TOT_W-1:0]  quoNext;
    logic              lastStep;
    logic              quoZero;
    logic              quoOver;
    logic              errNext;
    logic              doneNext;

    uart_glitch_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) uFilter (
        .clock     (clock),
        .reset     (reset),
        .rxIn      (RxD),
        .rxFiltered(rxFilteredOut),
        .fallStrobe(fallStr),
        .riseStrobe(riseStr)
    );

    assign edgeNow = fallStr | riseStr;
    assign segMax  = &segCnt;
    assign hiBound = {1'b0, len0} + {3'b000, len0[SEG_W-1:2]};
    assign loBound = len0 - {2'b00, len0[SEG_W-1:2]};

    // One restoring step per cycle; dividend bits shift out as quotient bits shift in
    assign trial     = {divRem, divQuo[TOT_W-1]};
    assign trialDiff = trial - DENOM9;
    assign trialGe   = (trial >= DENOM9);
    assign remNext   = 8'(trialGe ? trialDiff : trial);
    assign quoNext   = {divQuo[TOT_W-2:0], trialGe};
    assign lastStep  = (divCnt == CNT_W'(TOT_W - 1));
    assign quoZero   = (quoNext == '0);
    assign quoOver   = |quoNext[TOT_W-1:16];

    assign busyOut = (state != IDLE);

    always_comb begin
        stateNext = state;
        errNext   = 1'b0;
        doneNext  = 1'b0;
        if (abortIn) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (startIn) stateNext = WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (rxFilteredOut) stateNext = WAIT_START;
                end
                WAIT_START: begin
                    if (fallStr) stateNext = MEASURE;
                end
                MEASURE: begin
                    if (segIdx == 4'd0) begin
                        if (segMax) begin
                            errNext   = 1'b1;
                            stateNext = IDLE;
                        end
                    end else if (({1'b0, segCnt} > hiBound) ||
                                 (edgeNow && (segCnt < loBound))) begin
                        errNext   = 1'b1;
                        stateNext = IDLE;
                    end else if (edgeNow && (segIdx == LAST_IDX)) begin
                        stateNext = CALC;
                    end
                end
                CALC: begin
                    if (lastStep) begin
                        stateNext = IDLE;
                        errNext   = quoZero;
                        doneNext  = ~quoZero;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            segIdx          <= '0;
            segCnt          <= '0;
            len0            <= '0;
            totCnt          <= '0;
            divQuo          <= '0;
            divRem          <= '0;
            divCnt          <= '0;
            divisorOut      <= '0;
            divisorValidOut <= 1'b0;
            donePulseOut    <= 1'b0;
            errorPulseOut   <= 1'b0;
        end else begin
            state         <= stateNext;
            donePulseOut  <= doneNext;
            errorPulseOut <= errNext;

            if ((state == IDLE) && startIn && !abortIn) begin
                divisorValidOut <= 1'b0;
            end
            if (doneNext) begin
                divisorValidOut <= 1'b1;
                divisorOut      <= quoOver ? 16'hFFFF : quoNext[15:0];
            end

            case (state)
                WAIT_START: begin
                    segIdx <= '0;
                    segCnt <= SEG_ONE;
                    totCnt <= TOT_ONE;
                end
                MEASURE: begin
                    totCnt <= (&totCnt) ? totCnt : totCnt + TOT_ONE;
                    if (edgeNow) begin
                        segCnt <= SEG_ONE;
                        segIdx <= segIdx + 4'd1;
                        if (segIdx == 4'd0) len0 <= segCnt;
                    end else begin
                        segCnt <= segMax ? segCnt : segCnt + SEG_ONE;
                    end
                    divQuo <= totCnt + TOT_W'(DIV_ROUND);
                    divRem <= '0;
                    divCnt <= '0;
                end
                CALC: begin
                    divQuo <= quoNext;
                    divRem <= remNext;
                    divCnt <= divCnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_autobaud_detector.sv
// tb/tb_uart_autobaud_detector.sv - directed self-checking bench for uart_autobaud_detector
module tb_uart_autobaud_detector;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        RxD     = 1'b1;
    logic        startIn = 1'b0;
    logic        abortIn = 1'b0;
    logic        rxFilteredOut;
    logic        busyOut;
    logic [15:0] divisorOut;
    logic        divisorValidOut;
    logic        donePulseOut;
    logic        errorPulseOut;

    int passCount  = 0;
    int totalCount = 0;
    int doneTotal  = 0;
    int errTotal   = 0;

    uart_autobaud_detector #(
        .SEG_W     (20),
        .FILTER_LEN(4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .RxD            (RxD),
        .rxFilteredOut  (rxFilteredOut),
        .startIn        (startIn),
        .abortIn        (abortIn),
        .busyOut        (busyOut),
        .divisorOut     (divisorOut),
        .divisorValidOut(divisorValidOut),
        .donePulseOut   (donePulseOut),
        .errorPulseOut  (errorPulseOut)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (donePulseOut) doneTotal++;
        if (errorPulseOut) errTotal++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulseStart();
        startIn = 1'b1;
        tick();
        startIn = 1'b0;
    endtask

    task automatic sendBits(input logic [7:0] data, input int period);
        RxD = 1'b0;
        repeat (period) tick();
        for (int b = 0; b < 8; b++) begin
            RxD = data[b];
            repeat (period) tick();
        end
    endtask

    task automatic waitPulse(input bit wantDone, input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if ((wantDone && donePulseOut) || (!wantDone && errorPulseOut)) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        totalCount++; if (rxFilteredOut !== 1'b1) $display("FAIL reset_rxFiltered: got %b want 1", rxFilteredOut); else passCount++;
        totalCount++; if (busyOut !== 1'b0) $display("FAIL reset_busy: got %b want 0", busyOut); else passCount++;
        totalCount++; if (divisorOut !== 16'd0) $display("FAIL reset_divisor: got %0d want 0", divisorOut); else passCount++;
        totalCount++; if (divisorValidOut !== 1'b0) $display("FAIL reset_valid: got %b want 0", divisorValidOut); else passCount++;
        totalCount++; if ({donePulseOut, errorPulseOut} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {donePulseOut, errorPulseOut}); else passCount++;
        reset = 1'b0;
        repeat (10) tick();
        totalCount++; if (busyOut !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busyOut); else passCount++;
    endtask

    task automatic test_measure_432();
        int d0, e0, n;
        pulseStart();
        totalCount++; if (busyOut !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busyOut); else passCount++;
        repeat (10) tick();
        d0 = doneTotal; e0 = errTotal;
        sendBits(8'h55, 432);
        RxD = 1'b1;
        waitPulse(1'b1, 100, n);
        totalCount++; if (n !== 31) $display("FAIL done_latency_432: got %0d want 31", n); else passCount++;
        totalCount++; if (divisorOut !== 16'd27) $display("FAIL divisor_432: got %0d want 27", divisorOut); else passCount++;
        totalCount++; if (divisorValidOut !== 1'b1) $display("FAIL valid_432: got %b want 1", divisorValidOut); else passCount++;
        totalCount++; if (busyOut !== 1'b0) $display("FAIL busy_at_done: got %b want 0", busyOut); else passCount++;
        repeat (5) tick();
        totalCount++; if ((doneTotal - d0) !== 1) $display("FAIL done_count_432: got %0d want 1", doneTotal - d0); else passCount++;
        totalCount++; if ((errTotal - e0) !== 0) $display("FAIL err_count_432: got %0d want 0", errTotal - e0); else passCount++;
    endtask

    task automatic test_glitch();
        int d0, e0, lowSeen;
        pulseStart();
        totalCount++; if (divisorValidOut !== 1'b0) $display("FAIL valid_cleared_on_start: got %b want 0", divisorValidOut); else passCount++;
        repeat (10) tick();
        d0 = doneTotal; e0 = errTotal; lowSeen = 0;
        RxD = 1'b0;
        repeat (2) tick();
        RxD = 1'b1;
        repeat (12) begin
            tick();
            if (rxFilteredOut !== 1'b1) lowSeen++;
        end
        totalCount++; if (lowSeen !== 0) $display("FAIL glitch_filtered: got %0d low cycles want 0", lowSeen); else passCount++;
        totalCount++; if (busyOut !== 1'b1) $display("FAIL glitch_busy: got %b want 1", busyOut); else passCount++;
        totalCount++; if ((doneTotal - d0 + errTotal - e0) !== 0) $display("FAIL glitch_pulses: got %0d want 0", doneTotal - d0 + errTotal - e0); else passCount++;
        abortIn = 1'b1;
        tick();
        abortIn = 1'b0;
        totalCount++; if (busyOut !== 1'b0) $display("FAIL glitch_abort_busy: got %b want 0", busyOut); else passCount++;
    endtask

    task automatic test_seg1_timeout();
        int d0, n;
        pulseStart();
        repeat (10) tick();
        d0 = doneTotal;
        RxD = 1'b0;
        repeat (432) tick();
        RxD = 1'b1;
        waitPulse(1'b0, 1000, n);
        totalCount++; if (n !== 548) $display("FAIL seg1_timeout_latency: got %0d want 548", n); else passCount++;
        totalCount++; if (divisorOut !== 16'd27) $display("FAIL seg1_divisor_kept: got %0d want 27", divisorOut); else passCount++;
        totalCount++; if (divisorValidOut !== 1'b0) $display("FAIL seg1_valid: got %b want 0", divisorValidOut); else passCount++;
        totalCount++; if (busyOut !== 1'b0) $display("FAIL seg1_busy: got %b want 0", busyOut); else passCount++;
        repeat (3) tick();
        totalCount++; if ((doneTotal - d0) !== 0) $display("FAIL seg1_done_count: got %0d want 0", doneTotal - d0); else passCount++;
    endtask

    task automatic test_min_period();
        int n;
        pulseStart();
        repeat (10) tick();
        sendBits(8'h55, 4);
        RxD = 1'b1;
        waitPulse(1'b0, 100, n);
        totalCount++; if (n !== 31) $display("FAIL period4_error_latency: got %0d want 31", n); else passCount++;
        totalCount++; if (divisorOut !== 16'd27) $display("FAIL period4_divisor_kept: got %0d want 27", divisorOut); else passCount++;
        repeat (5) tick();
        pulseStart();
        repeat (10) tick();
        sendBits(8'h55, 8);
        RxD = 1'b1;
        waitPulse(1'b1, 100, n);
        totalCount++; if (n !== 31) $display("FAIL period8_done_latency: got %0d want 31", n); else passCount++;
        totalCount++; if (divisorOut !== 16'd1) $display("FAIL period8_divisor: got %0d want 1", divisorOut); else passCount++;
        totalCount++; if (divisorValidOut !== 1'b1) $display("FAIL period8_valid: got %b want 1", divisorValidOut); else passCount++;
        repeat (5) tick();
    endtask

    task automatic test_abort();
        int d0, e0, n;
        pulseStart();
        repeat (10) tick();
        d0 = doneTotal; e0 = errTotal;
        RxD = 1'b0; repeat (432) tick();
        RxD = 1'b1; repeat (432) tick();
        RxD = 1'b0; repeat (432) tick();
        RxD = 1'b1; repeat (100) tick();
        abortIn = 1'b1;
        tick();
        abortIn = 1'b0;
        totalCount++; if (busyOut !== 1'b0) $display("FAIL abort_busy: got %b want 0", busyOut); else passCount++;
        repeat (600) tick();
        totalCount++; if ((doneTotal - d0 + errTotal - e0) !== 0) $display("FAIL abort_pulses: got %0d want 0", doneTotal - d0 + errTotal - e0); else passCount++;
        totalCount++; if (divisorOut !== 16'd1) $display("FAIL abort_divisor_kept: got %0d want 1", divisorOut); else passCount++;
        totalCount++; if (divisorValidOut !== 1'b0) $display("FAIL abort_valid: got %b want 0", divisorValidOut); else passCount++;
        pulseStart();
        repeat (10) tick();
        sendBits(8'h55, 432);
        RxD = 1'b1;
        waitPulse(1'b1, 100, n);
        totalCount++; if (n !== 31) $display("FAIL after_abort_latency: got %0d want 31", n); else passCount++;
        totalCount++; if (divisorOut !== 16'd27) $display("FAIL after_abort_divisor: got %0d want 27", divisorOut); else passCount++;
        repeat (5) tick();
    endtask

    task automatic test_reset_calc();
        pulseStart();
        repeat (10) tick();
        sendBits(8'h55, 432);
        RxD = 1'b1;
        repeat (15) tick();
        totalCount++; if (busyOut !== 1'b1) $display("FAIL calc_busy: got %b want 1", busyOut); else passCount++;
        reset   = 1'b1;
        startIn = 1'b1;
        #1;
        totalCount++; if (busyOut !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", busyOut); else passCount++;
        totalCount++; if (divisorOut !== 16'd0) $display("FAIL async_reset_divisor: got %0d want 0", divisorOut); else passCount++;
        totalCount++; if (divisorValidOut !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", divisorValidOut); else passCount++;
        totalCount++; if ({donePulseOut, errorPulseOut} !== 2'b00) $display("FAIL async_reset_pulses: got %b want 00", {donePulseOut, errorPulseOut}); else passCount++;
        totalCount++; if (rxFilteredOut !== 1'b1) $display("FAIL async_reset_rx: got %b want 1", rxFilteredOut); else passCount++;
        repeat (3) tick();
        totalCount++; if (busyOut !== 1'b0) $display("FAIL reset_start_ignored: got %b want 0", busyOut); else passCount++;
        reset   = 1'b0;
        startIn = 1'b0;
        repeat (3) tick();
        totalCount++; if (busyOut !== 1'b0) $display("FAIL post_calc_reset_busy: got %b want 0", busyOut); else passCount++;
        totalCount++; if (divisorOut !== 16'd0) $display("FAIL post_calc_reset_divisor: got %0d want 0", divisorOut); else passCount++;
    endtask

    initial begin
        test_reset();
        test_measure_432();
        test_glitch();
        test_seg1_timeout();
        test_min_period();
        test_abort();
        test_reset_calc();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
